ans_table_arb: RTL
==================

Name: ans_table_arb

Overview:
Two-requester arbiter for the shared frequency/cumulative table read port in the ANS core. Requester 0 is the encoder path and requester 1 is the decoder path. Each requester issues lookups (type + query) through a valid/ready handshake. The arbiter serialises the lookups onto the single table port using round-robin priority and returns each result to the requester that issued it. New grants are held off while the loader is rewriting the table.

Parameters:
TYPE_W, 2, width of lookup type field (table select)
Q_W, 8, query width (CNT_WIDTH+SYM_WIDTH)
R_W, 8, result width (CNT_WIDTH+SYM_WIDTH)

Ports:
clk  in  1  single clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
load_busy  in  1  loader is writing the table; high = no new grants
req_vld  in  2  bit i: requester i has a lookup pending
req_rdy  out  2  bit i: arbiter accepts requester i this cycle
req_type  in  2*TYPE_W  [i*TYPE_W +: TYPE_W] = requester i type
req_query  in  2*Q_W  [i*Q_W +: Q_W] = requester i query
rsp_vld  out  2  bit i: result for requester i valid
rsp_rdy  in  2  bit i: requester i takes result
rsp_data  out  R_W  result, shared bus, meaningful only with rsp_vld
tbl_req  out  1  lookup strobe to table
tbl_type  out  TYPE_W  captured type
tbl_query  out  Q_W  captured query
tbl_result  in  R_W  table read data
tbl_rdy  in  1  tbl_result valid for current tbl_req
busy  out  1  state != IDLE
grant_id  out  1  index of requester owning current transaction

Behaviour:
- Reset (rst=1 at edge): state=IDLE, req_rdy=0, rsp_vld=0, tbl_req=0, tbl_type/tbl_query/rsp_data=0, busy=0, grant_id=0, last_grant=1 (requester 0 wins the first contest). Reset mid-transaction drops it silently: no response is delivered.
- States: IDLE -> ISSUE -> RESP -> IDLE.
- IDLE:
  - Winner selection: only one req_vld set -> that requester; both set -> !last_grant.
  - req_rdy[winner]=1, combinational from state, req_vld, last_grant and load_busy; the other req_rdy bit is 0.
  - load_busy=1 or req_vld=0 -> req_rdy=2'b00.
  - On handshake (req_vld[i]&req_rdy[i]): capture type/query into tbl_type/tbl_query, set grant_id=i, go to ISSUE.
- ISSUE:
  - tbl_req=1; tbl_type and tbl_query held stable.
  - If tbl_rdy=1 in a cycle with tbl_req=1: capture tbl_result into rsp_data and go to RESP.
  - Otherwise wait indefinitely.
  - load_busy is ignored here; an in-flight lookup always completes.
- RESP:
  - rsp_vld[grant_id]=1, other bit 0; rsp_data held.
  - On rsp_rdy[grant_id]: set last_grant=grant_id and go to IDLE.
  - rsp_rdy on the non-granted bit is ignored.
- Latency: handshake at cycle N -> tbl_req from N+1 -> rsp_vld earliest N+2 (tbl_rdy at N+1). Best-case throughput is 1 lookup per 3 cycles.
- tbl_rdy outside ISSUE is ignored. req_vld may drop before acceptance with no effect. Once rsp_vld rises it stays high until taken.
- Fairness: with both requesters held continuously valid, grants strictly alternate.

Optional Feature:
Macro ANS_ARB_STATS_EN.
- Defined: adds output stat_cnt (16 bits) = {cnt1[7:0], cnt0[7:0]}.
  - cnti increments on each accepted request from requester i and saturates at 8'hFF.
  - Cleared by rst only.
- Undefined: port and counters are absent; all other behaviour is identical.

Test Plan:
- Single request: req_vld=2'b01, type=1, query=8'h3A, tbl_rdy=1 with tbl_result=8'h5C -> tbl_req at N+1 with tbl_query=8'h3A; rsp_vld=2'b01 and rsp_data=8'h5C at N+2; IDLE after rsp_rdy[0].
- Contention: both req_vld held for 4 transactions, rsp_rdy=2'b11 -> grant_id sequence 0,1,0,1; no overlapping rsp_vld.
- Table stall: tbl_rdy held low 5 cycles -> tbl_req and tbl_query stable all 5 cycles; result delivered in the cycle after tbl_rdy rises.
- load_busy: assert in IDLE with req_vld=2'b10 -> req_rdy=0 throughout. Assert during ISSUE -> transaction completes. Release -> grant next cycle.
- Response backpressure and reset: rsp_rdy low 3 cycles -> rsp_vld and rsp_data held. rst in RESP -> next cycle rsp_vld=0, busy=0, grant_id=0, requester 0 wins the next contest.
- ANS_ARB_STATS_EN: 300 accepted requests from requester 1 -> stat_cnt=16'hFF00.

Source files
------------

// File: rtl/ans_table_arb_if.sv
// Request/response and table-port bundle shared by the ANS table arbiter and its users.
// The arbiter connects through the slave modport; requesters and the table model use master.
interface ans_table_arb_if #(
  parameter int TYPE_W = 2,
  parameter int Q_W    = 8,
  parameter int R_W    = 8
);
  logic [1:0]          req_vld;
  logic [1:0]          req_rdy;
  logic [2*TYPE_W-1:0] req_type;
  logic [2*Q_W-1:0]    req_query;
  logic [1:0]          rsp_vld;
  logic [1:0]          rsp_rdy;
  logic [R_W-1:0]      rsp_data;
  logic                tbl_req;
  logic [TYPE_W-1:0]   tbl_type;
  logic [Q_W-1:0]      tbl_query;
  logic [R_W-1:0]      tbl_result;
  logic                tbl_rdy;

  modport slave (
    input  req_vld, req_type, req_query, rsp_rdy, tbl_result, tbl_rdy,
    output req_rdy, rsp_vld, rsp_data, tbl_req, tbl_type, tbl_query
  );

  modport master (
    output req_vld, req_type, req_query, rsp_rdy, tbl_result, tbl_rdy,
    input  req_rdy, rsp_vld, rsp_data, tbl_req, tbl_type, tbl_query
  );
endinterface

// File: rtl/ans_table_arb.sv
// Round-robin arbiter serialising encoder/decoder lookups onto the single ANS table read port.
// Optional per-requester acceptance counters are enabled by ANS_ARB_STATS_EN.
//
// state  | meaning
// IDLE   | waiting for a request, grants allowed when load_busy_i is low
// ISSUE  | tbl_req driven, waiting for tbl_rdy
// RESP   | result held on rsp_data until the owner takes it
module ans_table_arb #(
  parameter int TYPE_W = 2,
  parameter int Q_W    = 8,
  parameter int R_W    = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_busy_i,
  ans_table_arb_if.slave      bus,
  output logic                busy_o,
  output logic                grant_id_o
`ifdef ANS_ARB_STATS_EN
  ,
  output logic [15:0]         stat_cnt_o
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] RESP  = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              grant_id_q, grant_id_d;
  logic [TYPE_W-1:0] tbl_type_q, tbl_type_d;
  logic [Q_W-1:0]    tbl_query_q, tbl_query_d;
  logic [R_W-1:0]    rsp_data_q, rsp_data_d;

  logic              winner;
  logic [1:0]        req_rdy;
  logic              accept;

  // Contest goes to the requester that did not win last time.
  always_comb begin
    winner = bus.req_vld[1];
    if (bus.req_vld == 2'b11) winner = ~last_grant_q;
  end

  always_comb begin
    req_rdy = 2'b00;
    if (state_q == IDLE && !load_busy_i && bus.req_vld != 2'b00)
      req_rdy = winner ? 2'b10 : 2'b01;
  end

  assign accept = |(bus.req_vld & req_rdy);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_id_d   = grant_id_q;
    tbl_type_d   = tbl_type_q;
    tbl_query_d  = tbl_query_q;
    rsp_data_d   = rsp_data_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          grant_id_d  = winner;
          tbl_type_d  = bus.req_type[winner*TYPE_W +: TYPE_W];
          tbl_query_d = bus.req_query[winner*Q_W +: Q_W];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.tbl_rdy) begin
          rsp_data_d = bus.tbl_result;
          state_d    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_rdy[grant_id_q]) begin
          last_grant_d = grant_id_q;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_id_q   <= 1'b0;
      tbl_type_q   <= '0;
      tbl_query_q  <= '0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_id_q   <= grant_id_d;
      tbl_type_q   <= tbl_type_d;
      tbl_query_q  <= tbl_query_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.req_rdy   = req_rdy;
  assign bus.tbl_req   = (state_q == ISSUE);
  assign bus.tbl_type  = tbl_type_q;
  assign bus.tbl_query = tbl_query_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.rsp_vld   = (state_q == RESP) ? (grant_id_q ? 2'b10 : 2'b01) : 2'b00;
  assign busy_o        = (state_q != IDLE);
  assign grant_id_o    = grant_id_q;

`ifdef ANS_ARB_STATS_EN
  logic [7:0] cnt0_q, cnt0_d;
  logic [7:0] cnt1_q, cnt1_d;

  // Saturating counts of accepted requests per requester.
  always_comb begin
    cnt0_d = cnt0_q;
    cnt1_d = cnt1_q;
    if (bus.req_vld[0] && req_rdy[0] && cnt0_q != 8'hFF) cnt0_d = cnt0_q + 8'd1;
    if (bus.req_vld[1] && req_rdy[1] && cnt1_q != 8'hFF) cnt1_d = cnt1_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      cnt0_q <= cnt0_d;
      cnt1_q <= cnt1_d;
    end
  end

  assign stat_cnt_o = {cnt1_q, cnt0_q};
`endif

endmodule
